// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants and types for the UART receive controller.
// The optional interrupt is selected with the UART_RXC_IRQ_EN macro.
package uart_rx_ctrl_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_BAUD   = 2'd2;
   localparam logic [1:0] ADDR_CTRL   = 2'd3;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_OVR   = 2;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_IRQ_EN = 2;

   localparam logic [12:0] DEFAULT_BAUD = 13'd434;

   typedef enum logic {
      WAIT_RDY = 1'b0,
      ACK      = 1'b1
   } cap_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// CPU register bus for the UART receive controller.
interface uart_rx_ctrl_if;
   logic [1:0]  addr;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, wr_en, rd_en, wdata, input rdata);
   modport slave  (input addr, wr_en, rd_en, wdata, output rdata);
endinterface

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             push_ok, pop_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Memory-mapped UART receive controller: capture FSM, FIFO, register file.
// Define UART_RXC_IRQ_EN to build the irq output and CTRL irq_en bit.
module uart_rx_ctrl #(
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [12:0] DEFAULT_BAUD = uart_rx_ctrl_pkg::DEFAULT_BAUD
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_rx_ctrl_if.slave      bus,
   input  logic               rx_rdy,
   input  logic [7:0]         rx_data,
   output logic               clr_rdy,
   output logic [12:0]        baud_DB
`ifdef UART_RXC_IRQ_EN
   ,
   output logic               irq
`endif
);
   import uart_rx_ctrl_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   cap_state_e     state, state_nxt;
   logic           capture;
   logic           enable, irq_en, overrun;
   logic           wr_stat, wr_ctrl, flush, pop, valid;
   logic           full, empty;
   logic [CW-1:0]  count;
   logic [7:0]     head;
   logic [31:0]    rd_mux;
   logic           unused;

   assign wr_stat = bus.wr_en && (bus.addr == ADDR_STATUS);
   assign wr_ctrl = bus.wr_en && (bus.addr == ADDR_CTRL);
   assign flush   = wr_ctrl && bus.wdata[CTRL_FLUSH];
   // Flush beats a same-cycle pop: the read reports no data.
   assign pop     = bus.rd_en && (bus.addr == ADDR_DATA) && !flush;
   assign valid   = !empty && !flush;
   assign unused  = ^bus.wdata[31:13];

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture && !flush),
      .pop   (pop),
      .flush (flush),
      .wdata (rx_data),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Capture FSM: one clr_rdy pulse per byte, then wait for rdy to drop.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         WAIT_RDY: if (rx_rdy && enable) begin
            capture   = 1'b1;
            state_nxt = ACK;
         end
         ACK:      if (!rx_rdy) state_nxt = WAIT_RDY;
         default:  state_nxt = WAIT_RDY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= WAIT_RDY;
         clr_rdy <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_rdy <= capture;
      end
   end

   // Overrun: a byte arrived with no room; a same-cycle pop makes room.
   always_ff @(posedge clk) begin
      if (!rst_n || flush)
         overrun <= 1'b0;
      else if (capture && full && !(pop && !empty))
         overrun <= 1'b1;
      else if (wr_stat && bus.wdata[STAT_OVR])
         overrun <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         baud_DB <= DEFAULT_BAUD;
         enable  <= 1'b1;
      end else if (bus.wr_en) begin
         if (bus.addr == ADDR_BAUD) baud_DB <= bus.wdata[12:0];
         if (bus.addr == ADDR_CTRL) enable  <= bus.wdata[CTRL_EN];
      end
   end

`ifdef UART_RXC_IRQ_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_en <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (wr_ctrl) irq_en <= bus.wdata[CTRL_IRQ_EN];
         irq <= irq_en && (!empty || overrun);
      end
   end
`else
   assign irq_en = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      case (bus.addr)
         ADDR_DATA:   rd_mux = {23'b0, valid, valid ? head : 8'h00};
         ADDR_STATUS: rd_mux = {16'b0, 8'(count), 5'b0, overrun, full, empty};
         ADDR_BAUD:   rd_mux = {19'b0, baud_DB};
         ADDR_CTRL:   rd_mux = {29'b0, irq_en, 1'b0, enable};
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)          bus.rdata <= '0;
      else if (bus.rd_en)  bus.rdata <= rd_mux;
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (default depth 8).
module tb_uart_rx_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_rdy;
   logic [7:0]  rx_data;
   logic        clr_rdy;
   logic [12:0] baud_DB;
`ifdef UART_RXC_IRQ_EN
   logic        irq;
`endif
   int checks = 0;
   int failures = 0;
   int pulses = 0;

   uart_rx_ctrl_if bus();

   uart_rx_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .rx_rdy  (rx_rdy),
      .rx_data (rx_data),
      .clr_rdy (clr_rdy),
      .baud_DB (baud_DB)
`ifdef UART_RXC_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (clr_rdy) pulses++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.addr = a; bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      d = bus.rdata;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] d;
      rd(a, d);
      chk(tag, d, exp);
   endtask

   task automatic wait_clr();
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (clr_rdy) begin seen = 1'b1; break; end
      end
      chk("clr_wait", {31'b0, seen}, 32'd1);
   endtask

   // Receiver model: hold rdy until clr_rdy is seen, drop it one cycle later.
   task automatic rx_byte(input logic [7:0] b);
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = b;
      wait_clr();
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int p0;
      rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
      bus.addr = 2'd0; bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wdata = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_clr", {31'b0, clr_rdy}, 32'h0);
      chk("rst_baud", {19'b0, baud_DB}, 32'd434);
`ifdef UART_RXC_IRQ_EN
      chk("rst_irq", {31'b0, irq}, 32'h0);
`endif
      rd_chk("rst_baud_reg", 2'd2, 32'd434);
      rd_chk("rst_status", 2'd1, 32'h1);
      rd_chk("rst_ctrl", 2'd3, 32'h1);

      // Single byte
      p0 = pulses;
      rx_byte(8'h5A);
      chk("one_pulse", pulses - p0, 32'd1);
      rd_chk("one_status", 2'd1, 32'h100);
      rd_chk("one_data", 2'd0, 32'h15A);
      rd_chk("one_empty", 2'd1, 32'h1);

      // Overflow by one
      for (int i = 1; i <= 9; i++) rx_byte(8'(i));
      rd_chk("ovf_status", 2'd1, 32'h806);
      for (int i = 1; i <= 8; i++) rd_chk("ovf_data", 2'd0, 32'h100 | i);
      rd_chk("ovf_9th", 2'd0, 32'h0);
      rd_chk("ovf_sticky", 2'd1, 32'h5);
      wr(2'd1, 32'h4);
      rd_chk("ovf_clear", 2'd1, 32'h1);

      // Full FIFO: push and pop in the same cycle
      for (int i = 0; i < 8; i++) rx_byte(8'(8'h10 + i));
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h18; bus.addr = 2'd0; bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk("fullpp_data", bus.rdata, 32'h110);
      chk("fullpp_clr", {31'b0, clr_rdy}, 32'h1);
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("fullpp_status", 2'd1, 32'h802);
      for (int i = 0; i < 8; i++) rd_chk("fullpp_order", 2'd0, 32'h100 | (8'h11 + i));

      // Flush on the capture cycle
      rx_byte(8'h66);
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h77;
      bus.addr = 2'd3; bus.wdata = 32'h2; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      chk("flush_clr", {31'b0, clr_rdy}, 32'h1);
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("flush_status", 2'd1, 32'h1);
      rd_chk("flush_data", 2'd0, 32'h0);
      rd_chk("flush_ctrl", 2'd3, 32'h0);

      // Disabled: byte stays held until enable returns
      p0 = pulses;
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h33;
      repeat (5) @(negedge clk);
      chk("dis_pulses", pulses - p0, 32'd0);
      rd_chk("dis_status", 2'd1, 32'h1);
      wr(2'd3, 32'h1);
      wait_clr();
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("en_status", 2'd1, 32'h100);
      rd_chk("en_data", 2'd0, 32'h133);

      // Empty FIFO: push and pop in the same cycle
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h44; bus.addr = 2'd0; bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk("emptypp_data", bus.rdata, 32'h0);
      chk("emptypp_clr", {31'b0, clr_rdy}, 32'h1);
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("emptypp_status", 2'd1, 32'h100);
      rd_chk("emptypp_pop", 2'd0, 32'h144);

      // CTRL irq_en bit
      wr(2'd3, 32'h5);
`ifdef UART_RXC_IRQ_EN
      rd_chk("ctrl_irqen", 2'd3, 32'h5);
      chk("irq_idle", {31'b0, irq}, 32'h0);
      rx_byte(8'h21);
      chk("irq_set", {31'b0, irq}, 32'h1);
      rd_chk("irq_pop", 2'd0, 32'h121);
      @(negedge clk);
      chk("irq_fall", {31'b0, irq}, 32'h0);
      wr(2'd3, 32'h1);
`else
      rd_chk("ctrl_irqen", 2'd3, 32'h1);
`endif

      // Baud write during a capture
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h55;
      bus.addr = 2'd2; bus.wdata = 32'h1B2; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      chk("baud_out", {19'b0, baud_DB}, 32'h1B2);
      chk("baud_clr", {31'b0, clr_rdy}, 32'h1);
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("baud_data", 2'd0, 32'h155);
      rd_chk("baud_reg", 2'd2, 32'h1B2);

      // Reset mid-handshake, byte recaptured afterwards
      @(negedge clk);
      rx_rdy = 1'b1; rx_data = 8'h99;
      @(negedge clk);
      chk("mid_clr", {31'b0, clr_rdy}, 32'h1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_clr", {31'b0, clr_rdy}, 32'h0);
      chk("mid_rst_baud", {19'b0, baud_DB}, 32'd434);
      chk("mid_rst_rdata", bus.rdata, 32'h0);
      rst_n = 1'b1;
      wait_clr();
      @(negedge clk);
      rx_rdy = 1'b0;
      repeat (2) @(negedge clk);
      rd_chk("recap_status", 2'd1, 32'h100);
      rd_chk("recap_data", 2'd0, 32'h199);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
